segre_dcache_store_buffer: RTL and testbench

- Write-through store buffer directly downstream of the data cache data array.
- Accepts each committed store (address, raw word data, memop_data_type_e) in the same cycle the data array writes it.
- Queues stores in a small FIFO and drains them one at a time to the memory/MMU side over a request/grant/done handshake, generating byte enables and lane-aligned data.
- Flags loads that hit a pending store word so the pipeline stalls until that store has drained.

---
 rtl/segre_dcache_store_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_segre_dcache_store_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_store_buffer.sv
// ---------------------------------------------------------------------------
// segre_dcache_store_buffer
//   Write-through store buffer sitting behind the dcache data array. Every
//   committed store is captured into a small FIFO and drained, oldest first,
//   to the memory side over a req/gnt/done handshake with lane-aligned data
//   and byte enables. Loads that hit a pending store word are flagged so the
//   pipeline can stall until that store has drained.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   st_valid_i/st_ready_o   store handshake from the dcache write path
//   st_addr_i/st_data_i     store byte address, right-aligned store data
//   st_type_i               BYTE / HALF / WORD
//   ld_valid_i/ld_addr_i    load lookup; ld_conflict_o flags a pending hit
//   mem_req_o/mem_gnt_i     write request / accept to memory
//   mem_done_i              memory write completed
//   mem_addr_o/data_o/be_o  word-aligned address, lane data, byte enables
//   empty_o, count_o        buffer status
// ---------------------------------------------------------------------------
package segre_dcache_store_buffer_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

module segre_dcache_store_buffer
  import segre_dcache_store_buffer_pkg::*;
#(
  parameter int SB_DEPTH  = 4,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        st_valid_i,
  output logic                        st_ready_o,
  input  logic [ADDR_SIZE-1:0]        st_addr_i,
  input  logic [WORD_SIZE-1:0]        st_data_i,
  input  memop_data_type_e            st_type_i,
  input  logic                        ld_valid_i,
  input  logic [ADDR_SIZE-1:0]        ld_addr_i,
  output logic                        ld_conflict_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_done_i,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  output logic [WORD_SIZE-1:0]        mem_data_o,
  output logic [3:0]                  mem_be_o,
  output logic                        empty_o,
  output logic [$clog2(SB_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_SIZE - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_be(input memop_data_type_e t, input logic [1:0] off);
    logic [3:0] be;
    case (t)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = 4'b0011 << off;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;  // unknown size: write nothing
    endcase
    return be;
  endfunction

  // Replicate right-aligned data across every lane it could land in.
  function automatic logic [WORD_SIZE-1:0] lane_data(input memop_data_type_e t,
                                                     input logic [WORD_SIZE-1:0] d);
    logic [WORD_SIZE-1:0] r;
    case (t)
      BYTE:    r = {4{d[7:0]}};
      HALF:    r = {2{d[15:0]}};
      WORD:    r = d;
      default: r = {WORD_SIZE{1'b0}};
    endcase
    return r;
  endfunction

  state_e               state_r;
  state_e               state_s;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [SB_DEPTH-1:0]  valid_r;
  logic [WA_W-1:0]      waddr_r [SB_DEPTH];
  logic [WORD_SIZE-1:0] data_r  [SB_DEPTH];
  logic [3:0]           be_r    [SB_DEPTH];

  logic full_s;
  logic push_s;
  logic pop_s;
  logic unused_ld_off_s;

  // The byte offset of a load never matters: conflicts are per word.
  assign unused_ld_off_s = ^ld_addr_i[1:0];

  assign full_s = (count_r == CNT_W'(SB_DEPTH));
  assign push_s = st_valid_i && !full_s;
  // The head is retired only once memory reports the write done.
  assign pop_s  = (state_r == S_WAIT) && mem_done_i;

  // Drain FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Drain FSM next-state: done is honoured only in WAIT, so a gnt+done
  // pair seen in REQ acts as a plain grant.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != CNT_W'(0)) state_s = S_REQ;
        else                      state_s = S_IDLE;
      end
      S_REQ: begin
        if (mem_gnt_i) state_s = S_WAIT;
        else           state_s = S_REQ;
      end
      S_WAIT: begin
        if (mem_done_i) begin
          if (count_r > CNT_W'(1)) state_s = S_REQ;
          else                     state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at SB_DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: lane-aligned data and byte enables are formed at push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {SB_DEPTH{1'b0}};
      for (int i = 0; i < SB_DEPTH; i++) begin
        waddr_r[i] <= {WA_W{1'b0}};
        data_r[i]  <= {WORD_SIZE{1'b0}};
        be_r[i]    <= 4'b0000;
      end
    end else begin
      if (pop_s) valid_r[rd_ptr_r] <= 1'b0;
      if (push_s) begin
        valid_r[wr_ptr_r] <= 1'b1;
        waddr_r[wr_ptr_r] <= st_addr_i[ADDR_SIZE-1:2];
        data_r[wr_ptr_r]  <= lane_data(st_type_i, st_data_i);
        be_r[wr_ptr_r]    <= lane_be(st_type_i, st_addr_i[1:0]);
      end
    end
  end

  // Memory request: head entry is presented only while requesting.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = {ADDR_SIZE{1'b0}};
    mem_data_o = {WORD_SIZE{1'b0}};
    mem_be_o   = 4'b0000;
    if (state_r == S_REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = {waddr_r[rd_ptr_r], 2'b00};
      mem_data_o = data_r[rd_ptr_r];
      mem_be_o   = be_r[rd_ptr_r];
    end else begin
      mem_req_o  = 1'b0;
    end
  end

  // Load lookup against every pending entry, in-flight head included.
  always_comb begin
    ld_conflict_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (ld_valid_i && valid_r[i] && (waddr_r[i] == ld_addr_i[ADDR_SIZE-1:2])) begin
        ld_conflict_o = 1'b1;
      end else begin
        ld_conflict_o = ld_conflict_o;
      end
    end
  end

  assign st_ready_o = !full_s;
  assign count_o    = count_r;
  assign empty_o    = (count_r == CNT_W'(0)) && (state_r == S_IDLE);

endmodule

// File: tb/tb_segre_dcache_store_buffer.sv
// ---------------------------------------------------------------------------
// Bench for segre_dcache_store_buffer. A driver issues directed and random
// stores/loads; a monitor keeps a queue of pending stores (the reference
// model), plays the memory side and compares every DUT output against it.
// ---------------------------------------------------------------------------
module tb_segre_dcache_store_buffer;
  import segre_dcache_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  memop_data_type_e st_type;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             ld_conflict;
  logic             mem_req;
  logic             mem_gnt;
  logic             mem_done;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic [3:0]       mem_be;
  logic             empty;
  logic [2:0]       count;

  segre_dcache_store_buffer #(.SB_DEPTH(DEPTH), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_type_i(st_type),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_conflict_o(ld_conflict),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_done_i(mem_done),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
    .empty_o(empty), .count_o(count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];          // pending stores, oldest first; head stays until done
  bit   outstanding;   // head granted, waiting for done
  int   stall;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   gnt_pct  = 100;
  int   done_pct = 100;
  int   spur_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected memory write for a store, from the lane rules in plain arithmetic.
  function automatic exp_t model_store(input logic [31:0] a, input logic [31:0] d,
                                       input memop_data_type_e t);
    exp_t r;
    int   off;
    off    = int'(a % 32'd4);
    r.addr = a - 32'(off);
    case (t)
      BYTE: begin
        r.be   = 4'(1 << off);
        r.data = (d & 32'h0000_00FF) * 32'h0101_0101;
      end
      HALF: begin
        r.be   = 4'(3 << off);
        r.data = (d & 32'h0000_FFFF) * 32'h0001_0001;
      end
      default: begin
        r.be   = 4'hF;
        r.data = d;
      end
    endcase
    return r;
  endfunction

  // Monitor + memory responder: compare at negedge, drive memory after posedge.
  initial begin
    mem_gnt     = 1'b0;
    mem_done    = 1'b0;
    outstanding = 1'b0;
    stall       = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req",      32'(mem_req),     32'd0);
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_empty",    32'(empty),       32'd1);
        chk("rst_ready",    32'(st_ready),    32'd1);
        chk("rst_conflict", 32'(ld_conflict), 32'd0);
        chk("rst_addr",     mem_addr,         32'd0);
        chk("rst_be",       32'(mem_be),      32'd0);
        q.delete();
        outstanding = 1'b0;
        stall       = 0;
      end else begin
        bit hit;
        bit accept;
        hit = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
        chk("count",    32'(count),       32'(q.size()));
        chk("ready",    32'(st_ready),    32'(q.size() < DEPTH));
        chk("empty",    32'(empty),       32'(q.size() == 0));
        chk("conflict", 32'(ld_conflict), 32'(ld_valid && hit));
        if (outstanding) begin
          chk("req_in_wait", 32'(mem_req), 32'd0);
          stall = 0;
        end else if (q.size() > 0) begin
          if (mem_req) begin
            chk("mem_addr", mem_addr,     q[0].addr);
            chk("mem_data", mem_data,     q[0].data);
            chk("mem_be",   32'(mem_be),  32'(q[0].be));
            stall = 0;
          end else begin
            stall++;
            if (stall > 2) chk("drain_stall", 32'(mem_req), 32'd1);
          end
        end else begin
          chk("req_when_empty", 32'(mem_req), 32'd0);
          stall = 0;
        end
        // Model update for the coming edge; ready reflects the current state.
        accept = st_valid && (q.size() < DEPTH);
        if (mem_done && outstanding) begin
          void'(q.pop_front());
          outstanding = 1'b0;
        end else if (mem_req && mem_gnt && !outstanding && q.size() > 0) begin
          outstanding = 1'b1;
        end
        if (accept) q.push_back(model_store(st_addr, st_data, st_type));
      end
      @(posedge clk);
      #1;
      mem_gnt  = ($urandom % 100) < gnt_pct;
      mem_done = outstanding ? (($urandom % 100) < done_pct) : (($urandom % 100) < spur_pct);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_type  = t;
    tick(1);
    st_valid = 1'b0;
  endtask

  // Driver: directed scenarios followed by a randomized soak.
  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    st_type  = WORD;
    ld_valid = 1'b0;
    ld_addr  = 32'd0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single byte, half and word stores with an eager memory.
    store(32'h0000_1003, 32'h0000_00AB, BYTE);
    tick(6);
    store(32'h0000_2002, 32'h0000_1234, HALF);
    store(32'h0000_3000, 32'hDEAD_BEEF, WORD);
    tick(10);

    // Fill with memory stalled; the fifth store must be dropped.
    gnt_pct = 0;
    for (int i = 0; i < 5; i++) store(32'h0000_5000 + 32'(4 * i), 32'h1111_0000 + 32'(i), WORD);
    tick(3);
    gnt_pct = 100;
    tick(20);
    // Wrap the pointers.
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) store(32'h0000_6000 + 32'(4 * i), 32'h2222_0000 + 32'(i), WORD);
    gnt_pct = 100;
    tick(15);

    // Load conflict against a pending word, then after it drains.
    gnt_pct = 0;
    store(32'h0000_4000, 32'hCAFE_F00D, WORD);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_4002;
    tick(1);
    ld_addr  = 32'h0000_4004;
    tick(1);
    gnt_pct = 100;
    tick(6);
    ld_addr  = 32'h0000_4002;
    tick(1);
    ld_valid = 1'b0;

    // Reset while a request is pending with two stores queued.
    gnt_pct = 0;
    store(32'h0000_7000, 32'h0000_0001, WORD);
    store(32'h0000_7004, 32'h0000_0002, WORD);
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Randomized soak: concurrent push/pop, spurious done, varying grant rate.
    gnt_pct  = 50;
    done_pct = 40;
    spur_pct = 10;
    for (int c = 0; c < 2000; c++) begin
      int t;
      int off;
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       gnt_pct = 0;
          1:       gnt_pct = 30;
          default: gnt_pct = 100;
        endcase
      end
      t = int'($urandom_range(0, 2));
      case (t)
        0:       off = int'($urandom_range(0, 3));
        1:       off = 2 * int'($urandom_range(0, 1));
        default: off = 0;
      endcase
      st_valid = $urandom_range(0, 1) == 1;
      st_addr  = 32'h0000_1000 + 32'($urandom_range(0, 9) * 4) + 32'(off);
      st_data  = $urandom;
      st_type  = memop_data_type_e'(t);
      ld_valid = $urandom_range(0, 1) == 1;
      ld_addr  = 32'h0000_1000 + 32'($urandom_range(0, 39));
      tick(1);
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;

    // Bounded drain.
    gnt_pct  = 100;
    done_pct = 100;
    spur_pct = 0;
    for (int w = 0; w < 100 && q.size() != 0; w++) tick(1);
    tick(2);
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
